regfile_param: RTL and testbench
================================

// Module: regfile_param
// PURPOSE
//   Parametrised register file for the datapath: one write port and two independently enabled read ports (A, B).
//   Depth, data width and a hard-wired zero register are configurable.
//   Reads are registered with 1-cycle latency; each read port has a valid flag.
//   Sits between writeback (write port) and the ALU operand latches (read ports A/B).
// PARAMETERS
//   DATA_W    32   width of every register and data port
//   DEPTH     16   number of registers; need not be a power of two
//   ADDR_W    5    address width of waddr/raddr_a/raddr_b; must satisfy 2**ADDR_W >= DEPTH
//   ZERO_REG  0    1: register 0 always reads 0 and ignores writes; 0: register 0 is a normal register
// PORTS
//   clk      in   1       clock; all state changes on its rising edge
//   rst      in   1       synchronous reset, active-high
//   we       in   1       write enable
//   waddr    in   ADDR_W  write address
//   wdata    in   DATA_W  write data
//   re_a     in   1       read enable, port A
//   raddr_a  in   ADDR_W  read address, port A
//   rdata_a  out  DATA_W  registered read data, port A
//   valid_a  out  1       rdata_a was updated on the last edge
//   re_b     in   1       read enable, port B
//   raddr_b  in   ADDR_W  read address, port B
//   rdata_b  out  DATA_W  registered read data, port B
//   valid_b  out  1       rdata_b was updated on the last edge
// BEHAVIOUR
//   Reset: synchronous and active-high. On a rising clk edge with rst=1:
//     - all DEPTH registers <= 0
//     - rdata_a, rdata_b <= 0
//     - valid_a, valid_b <= 0
//     - rst has priority over we, re_a and re_b in the same cycle
//   Write: on the edge with we=1, reg[waddr] <= wdata. The write is ignored when:
//     - waddr >= DEPTH, or
//     - ZERO_REG=1 and waddr=0
//   Read, port A (port B identical):
//     - re_a=1 at edge N: rdata_a <= value selected by raddr_a; valid_a=1 during cycle N+1
//     - re_a=0 at edge N: rdata_a holds its previous value; valid_a <= 0
//     - valid_a is a registered copy of re_a (forced to 0 by rst)
//   Read value selection:
//     - raddr >= DEPTH: returns 0
//     - ZERO_REG=1 and raddr=0: returns 0
//     - otherwise reg[raddr], subject to bypass (see CONFIGURATION)
//   Simultaneous events:
//     - Ports A and B may read the same address in the same cycle; both return the same value.
//     - A write and a read to the same address in the same cycle: result set by RF_BYPASS_EN.
//     - A write to an out-of-range address or to zero-reg 0 is never forwarded.
//   Reset mid-operation: a write or read in the same cycle as rst has no effect; the state is all zeros on the next cycle.
//   No state machine. State = register array + two output registers + two valid flops.
// CONFIGURATION
//   Macro RF_BYPASS_EN
//   - Defined: write-first. A read to the address being written in the same cycle returns wdata; the array updates as normal.
//   - Undefined: read-before-write. That read returns the old content; the new value is visible to reads from the next edge.
// TESTING
//   1. Reset: fill all 16 regs, pulse rst for 1 cycle -> every readback = 0, valid_a = valid_b = 0 on the cycle after rst.
//   2. Write/read: write 0xDEADBEEF to reg 5, then next cycle re_a=1 raddr_a=5
//        -> rdata_a = 0xDEADBEEF and valid_a = 1 one cycle later; with re_a=0 afterwards, rdata_a holds and valid_a = 0.
//   3. Same-cycle collision: reg 3 = 0x11, then we=1 waddr=3 wdata=0x22 with re_b=1 raddr_b=3
//        -> rdata_b = 0x22 with RF_BYPASS_EN, 0x11 without; a following read of reg 3 returns 0x22 in both builds.
//   4. ZERO_REG=1: write 0xFFFFFFFF to reg 0 while reading reg 0 on A and B in the same cycle
//        -> both ports return 0 in both builds; later reads of reg 0 also return 0.
//   5. Range check, DEPTH=12: write 0xA5A5A5A5 to address 13, then read 13 -> 0; regs 0..11 unchanged.
//   6. Dual read: reg 7 = 0x1234, reg 8 = 0x5678, same cycle raddr_a=7 and raddr_b=8
//        -> rdata_a = 0x1234 and rdata_b = 0x5678 together; then raddr_a = raddr_b = 8 -> both read 0x5678.

Source files
------------

// File: rtl/regfile_param_if.sv
// regfile_param_if: bus bundle for regfile_param.
//   master : writeback/operand-fetch side (drives we/waddr/wdata, re_x/raddr_x)
//   slave  : the register file (drives rdata_a/valid_a, rdata_b/valid_b)
// Signals:
//   we, waddr, wdata          write port
//   re_a, raddr_a             read request, port A
//   rdata_a, valid_a          registered read data/flag, port A
//   re_b, raddr_b             read request, port B
//   rdata_b, valid_b          registered read data/flag, port B
interface regfile_param_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
);
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic              re_a;
    logic [ADDR_W-1:0] raddr_a;
    logic [DATA_W-1:0] rdata_a;
    logic              valid_a;
    logic              re_b;
    logic [ADDR_W-1:0] raddr_b;
    logic [DATA_W-1:0] rdata_b;
    logic              valid_b;

    modport master (
        output we, waddr, wdata, re_a, raddr_a, re_b, raddr_b,
        input  rdata_a, valid_a, rdata_b, valid_b
    );

    modport slave (
        input  we, waddr, wdata, re_a, raddr_a, re_b, raddr_b,
        output rdata_a, valid_a, rdata_b, valid_b
    );
endinterface

// File: rtl/regfile_param.sv
// regfile_param: parametrised register file, one write port, two registered
// read ports (A/B) with 1-cycle latency and per-port valid flags.
// Ports:
//   clk  - clock, all state changes on rising edge
//   rst  - synchronous reset, active-high (clears array, read data, valids)
//   bus  - regfile_param_if.slave (write port + read ports A/B)
// Parameters: DATA_W, DEPTH (any value >= 1), ADDR_W (2**ADDR_W >= DEPTH),
//   ZERO_REG (1: register 0 reads as zero and ignores writes).
// Build option: define RF_BYPASS_EN for write-first reads (a same-cycle read
//   of the address being written returns wdata); otherwise read-before-write.
module regfile_param #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned ZERO_REG = 0
) (
    input logic            clk,
    input logic            rst,
    regfile_param_if.slave bus
);
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] regs [DEPTH];
    logic              writeOk;
    logic [DATA_W-1:0] readA;
    logic [DATA_W-1:0] readB;

    function automatic logic addrUsable(input logic [ADDR_W-1:0] a);
        return ({1'b0, a} < DEPTH_LIM) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    // Out-of-range and zero-register addresses never reach the array, so a
    // blocked write is also never forwarded to a same-cycle read.
    function automatic logic [DATA_W-1:0] readSel(
        input logic [ADDR_W-1:0] a,
        input logic              wOk,
        input logic [ADDR_W-1:0] wAddr,
        input logic [DATA_W-1:0] wData
    );
        logic [DATA_W-1:0] v;
        v = '0;
        if (addrUsable(a)) begin
`ifdef RF_BYPASS_EN
            if (wOk && (wAddr == a))
                v = wData;
            else
                v = regs[a[IDX_W-1:0]];
`else
            v = regs[a[IDX_W-1:0]];
            if (wOk && (wAddr == a))
                v = regs[a[IDX_W-1:0]];
`endif
        end
        return v;
    endfunction

    always_comb begin
        writeOk = bus.we && addrUsable(bus.waddr);
        readA   = readSel(bus.raddr_a, writeOk, bus.waddr, bus.wdata);
        readB   = readSel(bus.raddr_b, writeOk, bus.waddr, bus.wdata);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++)
                regs[i] <= '0;
            bus.rdata_a <= '0;
            bus.rdata_b <= '0;
            bus.valid_a <= 1'b0;
            bus.valid_b <= 1'b0;
        end else begin
            if (writeOk)
                regs[bus.waddr[IDX_W-1:0]] <= bus.wdata;
            if (bus.re_a)
                bus.rdata_a <= readA;
            if (bus.re_b)
                bus.rdata_b <= readB;
            bus.valid_a <= bus.re_a;
            bus.valid_b <= bus.re_b;
        end
    end
endmodule

// File: tb/tb_regfile_param.sv
// tb_regfile_param: drives two regfile_param instances with identical
// directed stimulus: inst 0 = DEPTH 16 / ZERO_REG 0, inst 1 = DEPTH 12 /
// ZERO_REG 1. A behavioural model tracks both; outputs are compared against
// it on every falling edge, plus hand-computed literal expectations.
module tb_regfile_param;
    logic        clk = 1'b0;
    logic        rst;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        reA;
    logic [4:0]  raddrA;
    logic        reB;
    logic [4:0]  raddrB;

    int nChecks = 0;
    int nErr    = 0;

    always #5 clk = ~clk;

    regfile_param_if #(.DATA_W(32), .ADDR_W(5)) ifA ();
    regfile_param_if #(.DATA_W(32), .ADDR_W(5)) ifB ();

    assign ifA.we = we;     assign ifB.we = we;
    assign ifA.waddr = waddr;   assign ifB.waddr = waddr;
    assign ifA.wdata = wdata;   assign ifB.wdata = wdata;
    assign ifA.re_a = reA;      assign ifB.re_a = reA;
    assign ifA.raddr_a = raddrA; assign ifB.raddr_a = raddrA;
    assign ifA.re_b = reB;      assign ifB.re_b = reB;
    assign ifA.raddr_b = raddrB; assign ifB.raddr_b = raddrB;

    regfile_param #(.DATA_W(32), .DEPTH(16), .ADDR_W(5), .ZERO_REG(0)) dut0 (
        .clk(clk), .rst(rst), .bus(ifA)
    );
    regfile_param #(.DATA_W(32), .DEPTH(12), .ADDR_W(5), .ZERO_REG(1)) dut1 (
        .clk(clk), .rst(rst), .bus(ifB)
    );

`ifdef RF_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    // ---------------- behavioural model ----------------
    int unsigned dep [2] = '{16, 12};
    bit          zr  [2] = '{1'b0, 1'b1};
    logic [31:0] mMem [2][16];
    logic [31:0] mRdA [2];
    logic [31:0] mRdB [2];
    logic        mVA  [2];
    logic        mVB  [2];
    bit          modelValid = 1'b0;

    function automatic bit usable(input int k, input logic [4:0] a);
        return (int'(a) < int'(dep[k])) && !(zr[k] && a == 5'd0);
    endfunction

    function automatic logic [31:0] mRead(input int k, input logic [4:0] a);
        if (!usable(k, a)) return 32'h0;
        if (BYPASS && we && usable(k, waddr) && waddr == a) return wdata;
        return mMem[k][a[3:0]];
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                for (int i = 0; i < 16; i++) mMem[k][i] = 32'h0;
                mRdA[k] = 32'h0; mRdB[k] = 32'h0;
                mVA[k] = 1'b0;   mVB[k] = 1'b0;
            end else begin
                if (reA) mRdA[k] = mRead(k, raddrA);
                if (reB) mRdB[k] = mRead(k, raddrB);
                mVA[k] = reA;
                mVB[k] = reB;
                if (we && usable(k, waddr)) mMem[k][waddr[3:0]] = wdata;
            end
        end
        if (rst) modelValid = 1'b1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (modelValid) begin
            check("i0 rdata_a", ifA.rdata_a, mRdA[0]);
            check("i0 rdata_b", ifA.rdata_b, mRdB[0]);
            check("i0 valid_a", {31'b0, ifA.valid_a}, {31'b0, mVA[0]});
            check("i0 valid_b", {31'b0, ifA.valid_b}, {31'b0, mVB[0]});
            check("i1 rdata_a", ifB.rdata_a, mRdA[1]);
            check("i1 rdata_b", ifB.rdata_b, mRdB[1]);
            check("i1 valid_a", {31'b0, ifB.valid_a}, {31'b0, mVA[1]});
            check("i1 valid_b", {31'b0, ifB.valid_b}, {31'b0, mVB[1]});
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we = 1'b0; reA = 1'b0; reB = 1'b0;
    endtask

    initial begin
        rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0;
        reA = 1'b0; raddrA = '0; reB = 1'b0; raddrB = '0;
        tick(); tick();
        rst = 1'b0;
        check("reset valid_a", {31'b0, ifA.valid_a}, 32'h0);
        check("reset rdata_a", ifA.rdata_a, 32'h0);

        // 1. fill every register, then reset with concurrent write/reads
        for (int i = 0; i < 16; i++) begin
            we = 1'b1; waddr = 5'(i); wdata = 32'(32'h01010101 * i + 1);
            tick();
        end
        we = 1'b0; reA = 1'b1; raddrA = 5'd4;
        tick();
        check("t1 fill i0", ifA.rdata_a, 32'h04040405);
        check("t1 fill i1", ifB.rdata_a, 32'h04040405);
        rst = 1'b1; we = 1'b1; waddr = 5'd2; wdata = 32'hCAFEF00D;
        reA = 1'b1; raddrA = 5'd4; reB = 1'b1; raddrB = 5'd5;
        tick();
        rst = 1'b0; idle();
        check("t1 rst valid_a", {31'b0, ifA.valid_a}, 32'h0);
        check("t1 rst valid_b", {31'b0, ifA.valid_b}, 32'h0);
        check("t1 rst rdata_a", ifA.rdata_a, 32'h0);
        for (int i = 0; i < 16; i++) begin
            reA = 1'b1; raddrA = 5'(i); reB = 1'b1; raddrB = 5'(15 - i);
            tick();
            check("t1 readback", ifA.rdata_a, 32'h0);
        end
        idle();

        // 2. write then read, then hold
        we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF;
        tick();
        we = 1'b0; reA = 1'b1; raddrA = 5'd5;
        tick();
        check("t2 rdata_a", ifA.rdata_a, 32'hDEADBEEF);
        check("t2 valid_a", {31'b0, ifA.valid_a}, 32'h1);
        reA = 1'b0; raddrA = 5'd9;
        tick();
        check("t2 hold rdata_a", ifA.rdata_a, 32'hDEADBEEF);
        check("t2 hold valid_a", {31'b0, ifA.valid_a}, 32'h0);

        // 3. same-cycle write/read collision
        we = 1'b1; waddr = 5'd3; wdata = 32'h11;
        tick();
        we = 1'b1; waddr = 5'd3; wdata = 32'h22; reB = 1'b1; raddrB = 5'd3;
        tick();
        check("t3 collide", ifA.rdata_b, BYPASS ? 32'h22 : 32'h11);
        we = 1'b0;
        tick();
        check("t3 after", ifA.rdata_b, 32'h22);
        idle();

        // 4. zero register (inst 1) vs normal reg 0 (inst 0)
        we = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF;
        reA = 1'b1; raddrA = 5'd0; reB = 1'b1; raddrB = 5'd0;
        tick();
        check("t4 zr a", ifB.rdata_a, 32'h0);
        check("t4 zr b", ifB.rdata_b, 32'h0);
        check("t4 r0 i0", ifA.rdata_a, BYPASS ? 32'hFFFFFFFF : 32'h0);
        we = 1'b0;
        tick();
        check("t4 zr later", ifB.rdata_a, 32'h0);
        check("t4 r0 i0 later", ifA.rdata_b, 32'hFFFFFFFF);
        idle();

        // 5. out-of-range address (inst 1 has DEPTH 12)
        we = 1'b1; waddr = 5'd13; wdata = 32'hA5A5A5A5; reA = 1'b1; raddrA = 5'd13;
        tick();
        check("t5 oor fwd i1", ifB.rdata_a, 32'h0);
        check("t5 fwd i0", ifA.rdata_a, BYPASS ? 32'hA5A5A5A5 : 32'h0);
        we = 1'b0;
        tick();
        check("t5 oor i1", ifB.rdata_a, 32'h0);
        check("t5 in range i0", ifA.rdata_a, 32'hA5A5A5A5);
        for (int i = 0; i < 12; i++) begin
            reA = 1'b1; raddrA = 5'(i); reB = 1'b1; raddrB = 5'(11 - i);
            tick();
        end
        raddrA = 5'd31; raddrB = 5'd16;
        tick();
        check("t5 addr31", ifA.rdata_a, 32'h0);
        check("t5 addr16", ifA.rdata_b, 32'h0);
        idle();

        // 6. dual read
        we = 1'b1; waddr = 5'd7; wdata = 32'h1234;
        tick();
        waddr = 5'd8; wdata = 32'h5678;
        tick();
        we = 1'b0; reA = 1'b1; raddrA = 5'd7; reB = 1'b1; raddrB = 5'd8;
        tick();
        check("t6 dual a", ifB.rdata_a, 32'h1234);
        check("t6 dual b", ifB.rdata_b, 32'h5678);
        raddrA = 5'd8;
        tick();
        check("t6 same a", ifA.rdata_a, 32'h5678);
        check("t6 same b", ifA.rdata_b, 32'h5678);
        idle();
        tick(); tick();

        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", nErr, nChecks);
        $finish;
    end
endmodule
